// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Round-robin arbiter that lets the CPU load/store path and the debug/loader
//   port share one single-port 32 x 8 synchronous data memory. At most one
//   access is issued per cycle. Grants are combinational. Load responses are
//   registered and arrive one cycle after the grant. Accesses at or beyond
//   DEPTH are blocked from the memory and reported through err. The block
//   also keeps a saturating count of cycles in which both ports requested.
//
// Ports
//   contCLK, reset            clock, asynchronous active-high reset
//   cpu_*_i / dbg_*_i         requester side: req, we, addr, wdata
//   cpu_gnt_o / dbg_gnt_o     request accepted this cycle (combinational)
//   cpu_rvalid_o / dbg_rvalid_o, cpu_rdata_o / dbg_rdata_o
//                             load response in the cycle after the grant
//   cpu_err_o / dbg_err_o     accepted access was out of range (registered)
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i
//                             single-port memory interface
//   conflict_cnt_o            saturating count of dual-request cycles
//
// Priority state
//   state    | meaning
//   PRIO_CPU | CPU wins the next conflict (after reset or after a debug grant)
//   PRIO_DBG | debug wins the next conflict (after a CPU grant)

module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              contCLK,
  input  logic              reset,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,

  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [4:0]        mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic [7:0]        conflict_cnt_o
);

  localparam int MEM_AW = 5;
  // One extra bit so the range compare stays exact even if DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    PRIO_CPU = 1'b0,
    PRIO_DBG = 1'b1
  } prio_e;

  prio_e prio_q, prio_d;

  logic              cpu_gnt, dbg_gnt;
  logic              acc_valid, in_range;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // rv: a load was accepted; ld: that load actually read memory (in range)
  logic cpu_rv_q, cpu_rv_d, cpu_ld_q, cpu_ld_d, cpu_err_q, cpu_err_d;
  logic dbg_rv_q, dbg_rv_d, dbg_ld_q, dbg_ld_d, dbg_err_q, dbg_err_d;

  logic [7:0] cnt_q, cnt_d;

  // Arbitration and priority next-state
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    prio_d  = prio_q;
    if (!reset) begin
      if (cpu_req_i && (!dbg_req_i || prio_q == PRIO_CPU)) begin
        cpu_gnt = 1'b1;
      end else if (dbg_req_i) begin
        dbg_gnt = 1'b1;
      end
    end
    if (cpu_gnt) begin
      prio_d = PRIO_DBG;
    end else if (dbg_gnt) begin
      prio_d = PRIO_CPU;
    end
  end

  // Access steering, memory strobes and response next-state
  always_comb begin
    sel_we    = dbg_gnt ? dbg_we_i    : cpu_we_i;
    sel_addr  = dbg_gnt ? dbg_addr_i  : cpu_addr_i;
    sel_wdata = dbg_gnt ? dbg_wdata_i : cpu_wdata_i;
    acc_valid = cpu_gnt | dbg_gnt;
    in_range  = ({1'b0, sel_addr} < DEPTH_L);

    mem_en_o    = acc_valid & in_range;
    mem_we_o    = acc_valid & in_range & sel_we;
    mem_addr_o  = mem_en_o ? sel_addr[MEM_AW-1:0] : '0;
    mem_wdata_o = mem_en_o ? sel_wdata : '0;

    cpu_rv_d  = cpu_gnt & ~cpu_we_i;
    cpu_ld_d  = cpu_rv_d & in_range;
    cpu_err_d = cpu_gnt & ~in_range;
    dbg_rv_d  = dbg_gnt & ~dbg_we_i;
    dbg_ld_d  = dbg_rv_d & in_range;
    dbg_err_d = dbg_gnt & ~in_range;

    cnt_d = cnt_q;
    if (cpu_req_i && dbg_req_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge contCLK or posedge reset) begin
    if (reset) begin
      prio_q    <= PRIO_CPU;
      cpu_rv_q  <= 1'b0;
      cpu_ld_q  <= 1'b0;
      cpu_err_q <= 1'b0;
      dbg_rv_q  <= 1'b0;
      dbg_ld_q  <= 1'b0;
      dbg_err_q <= 1'b0;
      cnt_q     <= 8'h00;
    end else begin
      prio_q    <= prio_d;
      cpu_rv_q  <= cpu_rv_d;
      cpu_ld_q  <= cpu_ld_d;
      cpu_err_q <= cpu_err_d;
      dbg_rv_q  <= dbg_rv_d;
      dbg_ld_q  <= dbg_ld_d;
      dbg_err_q <= dbg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_gnt_o    = cpu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign cpu_rvalid_o = cpu_rv_q;
  assign dbg_rvalid_o = dbg_rv_q;
  // Out-of-range loads get rvalid with zero data, so data is gated by ld, not rv.
  assign cpu_rdata_o  = cpu_ld_q ? mem_rdata_i : '0;
  assign dbg_rdata_o  = dbg_ld_q ? mem_rdata_i : '0;
  assign cpu_err_o    = cpu_err_q;
  assign dbg_err_o    = dbg_err_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port 32 x 8 data memory between two requesters: the CPU load/store path and a debug/loader port used to inspect or preload memory from the board switches. It performs round-robin arbitration, one memory access per cycle, with a request/grant handshake and a registered read response. It also range-checks the 8-bit addresses produced by register+offset arithmetic and counts contention cycles for on-board display.

## Interface
- ADDR_W, 8, requester address width (matches 8-bit register arithmetic)
- DATA_W, 8, data width
- DEPTH, 32, number of implemented memory words; legal addresses 0..DEPTH-1

Clock and reset: reset asynchronous, active-high; clock contCLK.
- contCLK  in  1  system clock (divided 1 Hz clock)
- reset  in  1  async active-high reset
- cpu_req, dbg_req  in  1  access request; must be held with stable fields until the matching gnt
- cpu_we, dbg_we  in  1  1 = store, 0 = load
- cpu_addr, dbg_addr  in  ADDR_W  word address
- cpu_wdata, dbg_wdata  in  DATA_W  store data
- cpu_gnt, dbg_gnt  out  1  combinational; request accepted this cycle
- cpu_rvalid, dbg_rvalid  out  1  registered; load response valid
- cpu_rdata, dbg_rdata  out  DATA_W  load data; 0x00 when rvalid is low
- cpu_err, dbg_err  out  1  registered; accepted access was out of range
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  5  memory word address (addr[4:0])
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after mem_en
- conflict_cnt  out  8  saturating count of cycles with both requests asserted

## Operation
- State: priority bit `prio` (0 = CPU, 1 = debug) plus response registers. `prio` always points to the port that was not granted most recently.
- Arbitration, each cycle:
  - Only one req high: grant it.
  - Both high: grant the port named by `prio`.
  - Neither high: no grant, no memory activity.
- Priority update: on any grant, set `prio` to the other port.
- Accepted access with addr < DEPTH:
  - mem_en = 1; mem_we = requester's we; mem_addr = addr[4:0]; mem_wdata = requester's wdata.
- Accepted access with addr >= DEPTH:
  - mem_en = 0 and mem_we = 0; no write occurs.
  - Granted port gets err = 1 next cycle.
  - If it was a load, the port also gets rvalid = 1 with rdata = 0x00.
- Stores produce no rvalid. err is asserted only for out-of-range accesses.
- conflict_cnt increments on every cycle with cpu_req & dbg_req and saturates at 0xFF. It clears only on reset.
- Memory contents are not owned by this block; reset does not touch memory.

## Timing
- Grant is combinational in cycle N; memory samples at the end of cycle N.
- Load response:
  - rvalid is high for exactly cycle N+1.
  - rdata = mem_rdata during N+1 and 0x00 otherwise.
  - Latency is 1 cycle.
- Back-to-back grants are allowed every cycle. A port may receive rvalid in N+1 while being granted again in N+1.
- Under continuous dual requests, grants alternate CPU, debug, CPU, ... Worst-case wait is 1 cycle.
- Requester drops req the cycle after its gnt, unless it issues a new access.
- Reset values: prio = 0 (CPU first); all gnt = 0 while reset is high; rvalid = 0, err = 0, rdata = 0x00; mem_en = 0, mem_we = 0; conflict_cnt = 0x00.
- Reset mid-operation: a pending response in flight is discarded (no rvalid after reset deasserts). The first post-reset conflict favours the CPU.
- Read/write to the same address in consecutive cycles: the write in N is visible to a read granted in N+1.

## Test plan
- Reset, then CPU load addr 0x05 (memory holds 0x05): cpu_gnt in cycle N; cpu_rvalid = 1 with cpu_rdata = 0x05 in N+1 only; dbg outputs stay 0.
- Both ports request continuously for 6 cycles starting from reset: grant order CPU, dbg, CPU, dbg, CPU, dbg; conflict_cnt = 6.
- Debug store 0xA7 to 0x10, then CPU load 0x10 in the next cycle: cpu_rdata = 0xA7.
- CPU load addr 0x25 (out of range): mem_en = 0; next cycle cpu_rvalid = 1, cpu_err = 1, cpu_rdata = 0x00. dbg store to 0xFF: no memory write, dbg_err pulses, no rvalid.
- Hold both requests for 300 cycles: conflict_cnt saturates at 0xFF and does not wrap.
- Assert reset in the cycle after a CPU load grant: no cpu_rvalid after reset releases; prio = CPU on the next conflict; conflict_cnt = 0.
